block_fetch_memory: RTL and testbench

Main-memory model that serves block refills to the direct-mapped cache controller on a miss. Accepts a level-held memRead request with a word address and fetches the aligned block of BLOCK_WORDS words. After a fixed access latency it presents the whole block on one wide bus and raises dataRdy. It holds the block until the requester drops memRead. It also provides a preload write port for testbench initialisation and a completed-refill counter.

---
 rtl/block_fetch_memory_if.sv | 32 +++
 rtl/block_fetch_memory.sv | 123 ++++++++++++
 tb/tb_block_fetch_memory.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/block_fetch_memory_if.sv
// +----------------------------------------------------------------------+
// | block_fetch_memory_if : refill request/response and preload bus      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface block_fetch_memory_if #(
   parameter int ADDR_W      = 15,
   parameter int WORD_W      = 32,
   parameter int BLOCK_WORDS = 4
);
   logic                          memRead;
   logic [ADDR_W-1:0]             adr;
   logic                          dataRdy;
   logic [WORD_W*BLOCK_WORDS-1:0] blockData;
   logic                          initWrite;
   logic [ADDR_W-1:0]             initAddr;
   logic [WORD_W-1:0]             initData;
   logic [15:0]                   readCount;

   modport master (
      output memRead, adr, initWrite, initAddr, initData,
      input  dataRdy, blockData, readCount
   );

   modport slave (
      input  memRead, adr, initWrite, initAddr, initData,
      output dataRdy, blockData, readCount
   );
endinterface

`default_nettype wire

// File: rtl/block_fetch_memory.sv
// +----------------------------------------------------------------------+
// | block_fetch_memory : main-memory model serving aligned block refills |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module block_fetch_memory #(
   parameter int ADDR_W      = 15,
   parameter int WORD_W      = 32,
   parameter int BLOCK_WORDS = 4,
   parameter int LATENCY     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   block_fetch_memory_if.slave     bus
);

   localparam int OFF_W = $clog2(BLOCK_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int DEPTH = 1 << ADDR_W;
   localparam int BUS_W = WORD_W * BLOCK_WORDS;
   localparam logic [CNT_W-1:0]  LAT_M1   = CNT_W'(LATENCY - 1);
   localparam logic [ADDR_W-1:0] ALN_MASK = ~ADDR_W'(BLOCK_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      READY = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              data_rdy_q, data_rdy_d;
   logic [BUS_W-1:0]  block_data_q, block_data_d;
   logic [15:0]       read_count_q, read_count_d;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [BUS_W-1:0]  fetch_block;
   logic              mem_we;

   // Array is not reset so preloaded contents survive a reset pulse.
   assign mem_we = rst && bus.initWrite && (state_q == IDLE);

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[bus.initAddr] <= bus.initData;
      end
   end

   generate
      for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_gather
         assign fetch_block[gi*WORD_W +: WORD_W] = mem[base_q | ADDR_W'(gi)];
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      cnt_d        = cnt_q;
      data_rdy_d   = data_rdy_q;
      block_data_d = block_data_q;
      read_count_d = read_count_q;
      case (state_q)
         IDLE: begin
            if (bus.memRead) begin
               base_d  = bus.adr & ALN_MASK;
               cnt_d   = LAT_M1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (!bus.memRead) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               block_data_d = fetch_block;
               data_rdy_d   = 1'b1;
               if (read_count_q != 16'hFFFF) begin
                  read_count_d = read_count_q + 16'd1;
               end
               state_d = READY;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         READY: begin
            if (!bus.memRead) begin
               data_rdy_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d    = IDLE;
            data_rdy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         base_q       <= '0;
         cnt_q        <= '0;
         data_rdy_q   <= 1'b0;
         block_data_q <= '0;
         read_count_q <= '0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         cnt_q        <= cnt_d;
         data_rdy_q   <= data_rdy_d;
         block_data_q <= block_data_d;
         read_count_q <= read_count_d;
      end
   end

   assign bus.dataRdy   = data_rdy_q;
   assign bus.blockData = block_data_q;
   assign bus.readCount = read_count_q;

endmodule

`default_nettype wire

// File: tb/tb_block_fetch_memory.sv
// +----------------------------------------------------------------------+
// | tb_block_fetch_memory : directed bench with transaction-level model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_block_fetch_memory;

   localparam int ADDR_W = 15;
   localparam int WORD_W = 32;
   localparam int BW     = 4;
   localparam int LAT    = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   block_fetch_memory_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_WORDS(BW)) bus ();

   block_fetch_memory #(
      .ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_WORDS(BW), .LATENCY(LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: a request is "open" from acceptance until memRead drops; the
   // block appears once the request has been held LAT edges.
   logic [31:0]  mmem [0:32767];
   logic         m_open = 1'b0;
   int           m_age  = 0;
   logic [14:0]  m_base = '0;
   logic         m_rdy  = 1'b0;
   logic [127:0] m_blk  = '0;
   logic [15:0]  m_cnt  = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_open = 1'b0;
         m_age  = 0;
         m_rdy  = 1'b0;
         m_blk  = '0;
         m_cnt  = '0;
      end else if (!m_open) begin
         if (bus.initWrite) mmem[bus.initAddr] = bus.initData;
         if (bus.memRead) begin
            m_open = 1'b1;
            m_age  = 0;
            m_base = {bus.adr[14:2], 2'b00};
         end
      end else if (!bus.memRead) begin
         m_open = 1'b0;
         m_rdy  = 1'b0;
      end else if (!m_rdy) begin
         m_age++;
         if (m_age == LAT) begin
            m_rdy = 1'b1;
            for (int i = 0; i < BW; i++) m_blk[i*32 +: 32] = mmem[m_base + 15'(i)];
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_dataRdy",   128'(bus.dataRdy),   128'(m_rdy));
      check("cyc_blockData", bus.blockData,       m_blk);
      check("cyc_readCount", 128'(bus.readCount), 128'(m_cnt));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [14:0] a, input logic [31:0] d);
      bus.initWrite = 1'b1;
      bus.initAddr  = a;
      bus.initData  = d;
      step();
      bus.initWrite = 1'b0;
   endtask

   task automatic wait_rdy(output int n);
      n = 0;
      while (!bus.dataRdy && n < 20) begin
         step();
         n++;
      end
   endtask

   logic [127:0] blk_a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
   logic [127:0] blk_c = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
   int n;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.memRead   = 1'b0;
      bus.adr       = '0;
      bus.initWrite = 1'b0;
      bus.initAddr  = '0;
      bus.initData  = '0;
      repeat (3) step();
      rst = 1'b1;
      step();
      check("rst_dataRdy",   128'(bus.dataRdy),   128'(0));
      check("rst_blockData", bus.blockData,       128'(0));
      check("rst_readCount", 128'(bus.readCount), 128'(0));

      for (int i = 0; i < 4; i++) begin
         preload(15'h0010 + 15'(i), 32'hA0 + 32'(i));
         preload(15'h0020 + 15'(i), 32'hB0 + 32'(i));
         preload(15'h0100 + 15'(i), 32'hC0 + 32'(i));
      end

      // Unaligned address fetches the aligned block
      bus.memRead = 1'b1;
      bus.adr     = 15'h0012;
      step();
      wait_rdy(n);
      check("lat_first",   128'(n),             128'(LAT));
      check("blk_first",   bus.blockData,       blk_a);
      check("cnt_first",   128'(bus.readCount), 128'(1));

      // Hold in READY while adr wanders; block must stay put
      for (int i = 0; i < 3; i++) begin
         bus.adr = 15'h0100;
         step();
         check("hold_rdy", 128'(bus.dataRdy), 128'(1));
         check("hold_blk", bus.blockData,     blk_a);
      end
      bus.memRead = 1'b0;
      step();
      check("drop_rdy", 128'(bus.dataRdy), 128'(0));
      check("drop_blk", bus.blockData,     blk_a);

      // Abort after two FETCH edges
      bus.memRead = 1'b1;
      bus.adr     = 15'h0020;
      step();
      step();
      step();
      bus.memRead = 1'b0;
      step();
      repeat (4) begin
         step();
         check("abort_rdy", 128'(bus.dataRdy), 128'(0));
      end
      check("abort_cnt", 128'(bus.readCount), 128'(1));
      check("abort_blk", bus.blockData,       blk_a);

      // Same-cycle preload + request, then a write during FETCH that must be dropped
      bus.initWrite = 1'b1;
      bus.initAddr  = 15'h0021;
      bus.initData  = 32'h55;
      bus.memRead   = 1'b1;
      bus.adr       = 15'h0020;
      step();
      bus.initAddr  = 15'h0022;
      bus.initData  = 32'h77;
      step();
      bus.initWrite = 1'b0;
      wait_rdy(n);
      check("lat_same",   128'(n + 1),               128'(LAT));
      check("same_word0", 128'(bus.blockData[31:0]),  128'(32'hB0));
      check("same_word1", 128'(bus.blockData[63:32]), 128'(32'h55));
      check("same_word2", 128'(bus.blockData[95:64]), 128'(32'hB2));
      check("same_cnt",   128'(bus.readCount),        128'(2));
      bus.memRead = 1'b0;
      step();

      // Later re-read of the 0x20 block: 0x22 still holds its old value
      bus.memRead = 1'b1;
      bus.adr     = 15'h0022;
      step();
      wait_rdy(n);
      check("reread_word2", 128'(bus.blockData[95:64]), 128'(32'hB2));
      check("reread_cnt",   128'(bus.readCount),        128'(3));
      bus.memRead = 1'b0;
      step();

      // Asynchronous reset while in READY
      bus.memRead = 1'b1;
      bus.adr     = 15'h0010;
      step();
      wait_rdy(n);
      check("pre_rst_rdy", 128'(bus.dataRdy), 128'(1));
      rst = 1'b0;
      #1;
      check("arst_dataRdy",   128'(bus.dataRdy),   128'(0));
      check("arst_blockData", bus.blockData,       128'(0));
      check("arst_readCount", 128'(bus.readCount), 128'(0));
      bus.memRead = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();

      // Back-to-back refills separated by one memRead-low sample
      bus.memRead = 1'b1;
      bus.adr     = 15'h0010;
      step();
      wait_rdy(n);
      check("b2b_lat1", 128'(n),       128'(LAT));
      check("b2b_blk1", bus.blockData, blk_a);
      bus.memRead = 1'b0;
      step();
      bus.memRead = 1'b1;
      bus.adr     = 15'h0100;
      step();
      wait_rdy(n);
      check("b2b_lat2", 128'(n),             128'(LAT));
      check("b2b_blk2", bus.blockData,       blk_c);
      check("b2b_cnt",  128'(bus.readCount), 128'(2));
      bus.memRead = 1'b0;
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
